alu_share_ctrl: RTL
===================

# alu_share_ctrl

Sequencing controller that shares the single 8-bit `alu` between two requesters: the instruction execute path (requester 0) and an auxiliary unit (requester 1). It arbitrates requests, registers operands and ALUOP onto the ALU inputs, waits a programmable number of cycles for the ALU's internal delays to settle, then captures RESULT/ZERO and returns them with a one-cycle done pulse. It sits between the requesters and the `alu` instance in the datapath.

## Interface
- SETTLE_CYCLES, 2: cycles the ALU inputs are held before capture; legal range 1..15; must cover the worst-case ALU delay (ADD, 2 time units) within the clock period.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req0, req1  in  1  operation request from each requester.
- op0, op1  in  3  ALUOP: 000 FORWARD, 001 ADD, 010 AND, 011 OR, 1xx reserved.
- a0, b0, a1, b1  in  8  operands; a maps to DATA1, b maps to DATA2.
- gnt0, gnt1  out  1  grant; high while the requester's operation occupies the ALU.
- done0, done1  out  1  one-cycle pulse; result and zero are valid in this cycle.
- result  out  8  captured ALU RESULT; holds its value until the next capture.
- zero  out  1  captured ALU ZERO.
- alu_data1, alu_data2  out  8  registered drive to ALU DATA1/DATA2.
- alu_select  out  3  registered drive to ALU SELECT.
- alu_result  in  8  from ALU RESULT.
- alu_zero  in  1  from ALU ZERO.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: if req0 or req1 is high at the edge, arbitrate, register the winner's op/a/b onto alu_select/alu_data1/alu_data2, set that gnt, load cnt=SETTLE_CYCLES, go to WAIT. With no request, stay in IDLE; the alu_* outputs hold their values.
- WAIT: decrement cnt each edge. At the edge where cnt==1, capture alu_result into result and alu_zero into zero, raise done for the granted requester, go to DONE.
- DONE: done is high for this cycle only. At the next edge, clear gnt and done and go to IDLE.
- Operands are latched at grant. A requester may drop req or change its operands after the grant, and the operation still completes with done.
- A requester must deassert req by the IDLE cycle that follows DONE. A req still high there is treated as a new operation.
- Reserved ops are passed through unchanged: the ALU returns 0, so result=0 and zero=1.
- Arithmetic is 8-bit and wraps (ALU behaviour). The controller never modifies data.
- Only one operation is in flight at a time. A request that loses arbitration waits in IDLE with gnt low.

## Timing
- Reset values: state IDLE, gnt0=gnt1=0, done0=done1=0, result=0, zero=0, alu_data1=alu_data2=0, alu_select=000, cnt=0, RR pointer favours requester 0.
- Latency: req sampled at edge E. gnt is high from E. done is high in the cycle after edge E+SETTLE_CYCLES. A request is accepted every SETTLE_CYCLES+2 cycles at most.
- With SETTLE_CYCLES=1, capture occurs at the first edge after the grant.
- Simultaneous req0 and req1 in IDLE are resolved as described under Configuration.
- RESET asserted mid-operation: return to IDLE at that edge with all reset values. No done pulse is issued, and the in-flight operation is discarded.
- RESET has priority over every other event in the same cycle.

## Configuration
- ALU_SHARE_RR_EN defined: round-robin arbitration. On a tie, the requester not granted most recently wins. The pointer updates on every grant.
- ALU_SHARE_RR_EN undefined: fixed priority, requester 0 always wins ties. Requester 1 can be starved; this is accepted for single-master builds.

## Structure
- Package alu_ctrl_pkg holds:
  - the FSM state enum (IDLE/WAIT/DONE);
  - ALUOP constants (ALUOP_FWD=000, ALUOP_ADD=001, ALUOP_AND=010, ALUOP_OR=011);
  - the counter width constant (4).
- One sub-module, alu_arb2: a two-input arbiter.
  - Inputs: req0, req1, and a grant-enable strobe from the FSM.
  - Outputs: a one-hot winner.
  - Holds the RR pointer under ALU_SHARE_RR_EN and is purely combinational otherwise.
- The FSM, counter, and capture registers live in alu_share_ctrl.

## Test plan
- Single ADD: req0, op0=001, a0=20, b0=15, SETTLE_CYCLES=2 -> gnt0 at the grant edge; done0 pulses for one cycle after the second edge; result=35, zero=0.
- Zero flag: req1, op1=010, a1=0xF0, b1=0x0F -> done1 pulses; result=0, zero=1. Then op1=011, a1=100, b1=250 -> result=254.
- Tie, RR build: req0 and req1 held continuously -> grants alternate 0,1,0,1. Fixed-priority build: requester 0 always wins and done1 never pulses.
- Req dropped after grant: req0 deasserted one cycle after the grant and a0 changed -> done0 still pulses with the result from the latched operands.
- Reset mid-WAIT: RESET high while cnt=1 -> no done pulse; all outputs return to reset values the next cycle; a subsequent request completes normally.
- Reserved op and wrap: op0=100 -> result=0, zero=1. op0=001, a0=200, b0=100 -> result=44.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller: FSM states,
// ALUOP encodings and the settle counter width.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] ALUOP_FWD = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_arb2.sv
// Two-input arbiter producing a one-hot winner while en is high.
// ALU_SHARE_RR_EN selects round-robin on ties; otherwise requester 0 wins.
module alu_arb2 (
`ifdef ALU_SHARE_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  output logic [1:0] win
);

`ifdef ALU_SHARE_RR_EN
  // fav1_q high means requester 1 is owed the next tie.
  logic fav1_q;

  always_comb begin
    win = 2'b00;
    if (en) begin
      if (req0 && req1) win = fav1_q ? 2'b10 : 2'b01;
      else              win = {req1, req0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        fav1_q <= 1'b0;
    else if (|win)  fav1_q <= win[0];
  end
`else
  always_comb begin
    win = 2'b00;
    if (en) begin
      if (req0)      win = 2'b01;
      else if (req1) win = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 8-bit ALU between two requesters: grant, drive registered
// operands, wait SETTLE_CYCLES, capture RESULT/ZERO and pulse done.
// Optional round-robin tie-breaking via ALU_SHARE_RR_EN.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       zero,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result,
  input  logic       alu_zero
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, zero_q;
  logic [7:0]       result_q, data1_q, data2_q;
  logic [2:0]       select_q;
  logic [1:0]       win;
  logic             arb_en;

  assign arb_en = (state_q == IDLE);

  alu_arb2 u_arb (
`ifdef ALU_SHARE_RR_EN
    .clk  (CLK),
    .rst  (RESET),
`endif
    .req0 (req0),
    .req1 (req1),
    .en   (arb_en),
    .win  (win)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= 8'h00;
      zero_q   <= 1'b0;
      data1_q  <= 8'h00;
      data2_q  <= 8'h00;
      select_q <= ALUOP_FWD;
    end else begin
      case (state_q)
        IDLE: begin
          if (|win) begin
            // Operands are latched here so requesters may move on after grant.
            select_q <= win[1] ? op1 : op0;
            data1_q  <= win[1] ? a1  : a0;
            data2_q  <= win[1] ? b1  : b0;
            gnt0_q   <= win[0];
            gnt1_q   <= win[1];
            cnt_q    <= SETTLE_LD;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 1) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
            done0_q  <= gnt0_q;
            done1_q  <= gnt1_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign alu_data1  = data1_q;
  assign alu_data2  = data2_q;
  assign alu_select = select_q;

  a_gnt_onehot: assert property (@(posedge CLK) !(gnt0_q && gnt1_q));
  a_done_gnt:   assert property (@(posedge CLK) (done0_q -> gnt0_q) && (done1_q -> gnt1_q));

endmodule
